// File: rtl/regfile_pkg.sv
// Shared defaults and writeback source encoding for the register-file
// writeback arbiter and its round-robin grant logic.
package regfile_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int CNT_WIDTH  = 8;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, and under
// contention the source named by ptr wins. Purely combinational.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic [1:0] req,
  input  src_e       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (ptr == SRC_MEM) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load-unit writebacks onto a single register-file write
// port with one cycle of latency, and counts contended cycles.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
  parameter int CNT_WIDTH  = regfile_pkg::CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  aluValid,
  input  logic [ADDR_WIDTH-1:0] aluReg,
  input  logic [DATA_WIDTH-1:0] aluData,
  output logic                  aluReady,
  input  logic                  memValid,
  input  logic [ADDR_WIDTH-1:0] memReg,
  input  logic [DATA_WIDTH-1:0] memData,
  output logic                  memReady,
  input  logic                  holdWb,
  output logic                  write,
  output logic [ADDR_WIDTH-1:0] writeReg,
  output logic [DATA_WIDTH-1:0] writeData,
  output logic [CNT_WIDTH-1:0]  contendCount
);
  import regfile_pkg::*;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] writeReg_q, writeReg_d;
  logic [DATA_WIDTH-1:0] writeData_q, writeData_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  src_e                  rrPtr_q, rrPtr_d;

  logic [1:0]            req, gnt;
  logic                  contended, xfer;
  logic [ADDR_WIDTH-1:0] xferReg;
  logic [DATA_WIDTH-1:0] xferData;

  // Reset and freeze mask the requests so neither source can be granted.
  assign req       = (rst || holdWb) ? 2'b00 : {memValid, aluValid};
  assign contended = aluValid && memValid && !holdWb;

  rr_arb2 u_arb (
    .req (req),
    .ptr (rrPtr_q),
    .gnt (gnt)
  );

  assign aluReady = gnt[0];
  assign memReady = gnt[1];
  assign xfer     = |gnt;
  assign xferReg  = gnt[1] ? memReg  : aluReg;
  assign xferData = gnt[1] ? memData : aluData;

  always_comb begin
    write_d     = 1'b0;
    writeReg_d  = writeReg_q;
    writeData_d = writeData_q;
    rrPtr_d     = rrPtr_q;
    cnt_d       = contended ? sat_inc(cnt_q) : cnt_q;
    if (xfer && (xferReg != '0)) begin
      write_d     = 1'b1;
      writeReg_d  = xferReg;
      writeData_d = xferData;
    end
    if (xfer && contended) begin
      rrPtr_d = gnt[1] ? SRC_ALU : SRC_MEM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_q     <= 1'b0;
      writeReg_q  <= '0;
      writeData_q <= '0;
      rrPtr_q     <= SRC_ALU;
      cnt_q       <= '0;
    end else begin
      write_q     <= write_d;
      writeReg_q  <= writeReg_d;
      writeData_q <= writeData_d;
      rrPtr_q     <= rrPtr_d;
      cnt_q       <= cnt_d;
    end
  end

  // A reset landing right after a transfer must also kill the pending strobe.
  assign write        = write_q && !rst;
  assign writeReg     = writeReg_q;
  assign writeData    = writeData_q;
  assign contendCount = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a behavioural model checked every
// cycle, plus hand-computed expectations at key points of each scenario.
module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          aluValid = 1'b0, memValid = 1'b0, holdWb = 1'b0;
  logic [AW-1:0] aluReg = '0, memReg = '0;
  logic [DW-1:0] aluData = '0, memData = '0;
  logic          aluReady, memReady, write;
  logic [AW-1:0] writeReg;
  logic [DW-1:0] writeData;
  logic [CW-1:0] contendCount;

  int vectors = 0;
  int miscompares = 0;

  regfile_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .aluValid(aluValid), .aluReg(aluReg), .aluData(aluData), .aluReady(aluReady),
    .memValid(memValid), .memReg(memReg), .memData(memData), .memReady(memReady),
    .holdWb(holdWb), .write(write), .writeReg(writeReg), .writeData(writeData),
    .contendCount(contendCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Behavioural model: whose turn it is under contention, the register
  // port contents, and the saturating contention tally.
  bit          m_ok = 0;
  bit          m_memTurn = 0;
  bit          m_write = 0;
  int unsigned m_reg = 0, m_data = 0, m_cnt = 0;

  function automatic logic [1:0] m_grant();
    if (rst || holdWb) return 2'b00;
    if (aluValid && memValid) return m_memTurn ? 2'b10 : 2'b01;
    return {memValid, aluValid};
  endfunction

  always @(posedge clk) begin
    logic [1:0]  g;
    int unsigned r, d;
    bit          both;
    if (rst) begin
      m_ok = 1; m_memTurn = 0; m_write = 0; m_reg = 0; m_data = 0; m_cnt = 0;
    end else begin
      g = m_grant();
      both = aluValid && memValid && !holdWb;
      if (both && m_cnt < CMAX) m_cnt = m_cnt + 1;
      m_write = 0;
      if (g != 2'b00) begin
        r = g[1] ? memReg : aluReg;
        d = g[1] ? memData : aluData;
        if (r != 0) begin
          m_write = 1; m_reg = r; m_data = d;
        end
        if (both) m_memTurn = !g[1];
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0] g;
    if (m_ok) begin
      g = m_grant();
      check("model aluReady", 64'(aluReady), 64'(g[0]));
      check("model memReady", 64'(memReady), 64'(g[1]));
      check("model write", 64'(write), 64'(m_write && !rst));
      check("model writeReg", 64'(writeReg), 64'(m_reg));
      check("model writeData", 64'(writeData), 64'(m_data));
      check("model contendCount", 64'(contendCount), 64'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                       input logic mv, input logic [AW-1:0] mr, input logic [DW-1:0] md);
    aluValid = av; aluReg = ar; aluData = ad;
    memValid = mv; memReg = mr; memData = md;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, with an ALU request presented that must be ignored.
    rst = 1;
    drive(1, 5'd3, 32'h1234, 0, 0, 0);
    check("rst aluReady", 64'(aluReady), 0);
    tick(); tick();
    check("rst write", 64'(write), 0);
    check("rst writeReg", 64'(writeReg), 0);
    check("rst writeData", 64'(writeData), 0);
    check("rst contendCount", 64'(contendCount), 0);

    // ALU only.
    rst = 0;
    drive(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    check("alu aluReady", 64'(aluReady), 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("alu write", 64'(write), 1);
    check("alu writeReg", 64'(writeReg), 5);
    check("alu writeData", 64'(writeData), 64'hDEADBEEF);
    tick();
    check("idle write", 64'(write), 0);
    check("idle writeReg hold", 64'(writeReg), 5);

    // Contention after reset: ALU, MEM, ALU.
    rst = 1; tick(); rst = 0;
    drive(1, 5'd1, 32'h11, 1, 5'd2, 32'h22);
    check("c1 aluReady", 64'(aluReady), 1);
    check("c1 memReady", 64'(memReady), 0);
    tick();
    drive(1, 5'd1, 32'h12, 1, 5'd2, 32'h22);
    check("c1 writeData", 64'(writeData), 64'h11);
    check("c2 memReady", 64'(memReady), 1);
    check("c2 aluReady", 64'(aluReady), 0);
    tick();
    drive(1, 5'd1, 32'h12, 1, 5'd2, 32'h23);
    check("c2 writeReg", 64'(writeReg), 2);
    check("c2 writeData", 64'(writeData), 64'h22);
    check("c3 aluReady", 64'(aluReady), 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("c3 writeData", 64'(writeData), 64'h12);
    check("c3 contendCount", 64'(contendCount), 3);
    tick();

    // Register 0 from the load unit.
    drive(0, 0, 0, 1, 5'd0, 32'h55);
    check("r0 memReady", 64'(memReady), 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("r0 write", 64'(write), 0);
    check("r0 writeReg hold", 64'(writeReg), 1);
    check("r0 writeData hold", 64'(writeData), 64'h12);

    // Freeze with both valid for 4 cycles; MEM's turn comes up on release.
    holdWb = 1;
    drive(1, 5'd3, 32'h33, 1, 5'd4, 32'h44);
    for (int i = 0; i < 4; i++) begin
      check("hold aluReady", 64'(aluReady), 0);
      check("hold memReady", 64'(memReady), 0);
      tick();
      check("hold write", 64'(write), 0);
    end
    check("hold contendCount", 64'(contendCount), 3);
    holdWb = 0; #1;
    check("release memReady", 64'(memReady), 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("release writeReg", 64'(writeReg), 4);
    check("release contendCount", 64'(contendCount), 4);
    tick();

    // Same destination from both sources: later grant lands last.
    drive(1, 5'd7, 32'hA, 1, 5'd7, 32'hB);
    tick();
    drive(0, 0, 0, 1, 5'd7, 32'hB);
    check("same first", 64'(writeData), 64'hA);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("same final reg", 64'(writeReg), 7);
    check("same final data", 64'(writeData), 64'hB);

    // Reset right after a transfer.
    drive(1, 5'd9, 32'h99, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    rst = 1; #1;
    check("rst-mid write", 64'(write), 0);
    tick();
    rst = 0;
    check("rst-mid writeReg", 64'(writeReg), 0);
    check("rst-mid writeData", 64'(writeData), 0);
    check("rst-mid contendCount", 64'(contendCount), 0);
    drive(1, 5'd6, 32'h66, 1, 5'd8, 32'h88);
    check("rst-mid alu first", 64'(aluReady), 1);
    tick();

    // Saturation over 300 contended cycles.
    rst = 1; tick(); rst = 0;
    drive(1, 5'd10, 32'hAA, 1, 5'd11, 32'hBB);
    for (int i = 0; i < 300; i++) tick();
    check("sat 300", 64'(contendCount), 255);
    tick(); tick();
    check("sat stays", 64'(contendCount), 255);
    drive(0, 0, 0, 0, 0, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
